control_unit: RTL

Finite-state sequencer for the 8-bit accumulator datapath (`DataPath`). It fetches each instruction, decodes opcode `IR75`, and drives every datapath control line (`IRload`, `JMPmux`, `PCload`, `Meminst`, `MemWr`, `Asel`, `Aload`, `Sub`) for one execute state per instruction. It also handles the Enter-key handshake for `input` and the `halt` stop condition. It sits beside `DataPath` in the processor top level, fed by the datapath status flags.

---
 rtl/control_pkg.sv | 44 ++++
 rtl/control_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared encodings for the accumulator-machine sequencer:
//   state_t       4-bit FSM state codes (also exported on the debug port)
//   OP_*          3-bit opcodes found in IR[7:5]
//   ASEL_*        source select codes for the A register input mux
//   exec_state()  maps an opcode to its execute state ({1, opcode})
// ---------------------------------------------------------------------------
package control_pkg;

  typedef enum logic [3:0] {
    ST_START  = 4'b0000,
    ST_FETCH  = 4'b0001,
    ST_DECODE = 4'b0010,
    ST_LOAD   = 4'b1000,
    ST_STORE  = 4'b1001,
    ST_ADD    = 4'b1010,
    ST_SUB    = 4'b1011,
    ST_INPUT  = 4'b1100,
    ST_JZ     = 4'b1101,
    ST_JPOS   = 4'b1110,
    ST_HALT   = 4'b1111
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'd0;
  localparam logic [1:0] ASEL_IN  = 2'd1;
  localparam logic [1:0] ASEL_RAM = 2'd2;

  // Every opcode value has a matching execute state, so the cast never
  // produces an out-of-enum code.
  function automatic state_t exec_state(input logic [2:0] op);
    return state_t'({1'b1, op});
  endfunction

endpackage

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Sequencer for the 8-bit accumulator datapath. Each instruction walks
// START -> FETCH -> DECODE -> execute; INPUT waits for an Enter press and
// HALT stays put until clear.
//
// Ports:
//   clk      in   system clock, rising edge
//   clear    in   synchronous active-high reset
//   IR75     in   opcode from the instruction register
//   Aeq0     in   accumulator == 0
//   Apos     in   accumulator > 0 (signed)
//   enter    in   Enter key level, already synchronised
//   IRload   out  load IR from RAM
//   JMPmux   out  PC source: 0 = PC+1, 1 = IR[4:0]
//   PCload   out  load PC
//   Meminst  out  RAM address: 0 = PC, 1 = IR[4:0]
//   MemWr    out  RAM write strobe
//   Asel     out  A source: 0 = add/sub, 1 = input, 2 = RAM
//   Aload    out  load A
//   Sub      out  0 = add, 1 = subtract
//   halted   out  high while in HALT
//   state    out  current state code, for debug
// ---------------------------------------------------------------------------
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] IR75,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       enter,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       halted,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   enter_q;
  logic   enterRise;

  // A press is counted only on a low-to-high transition of the key, so a
  // key held across two INPUT instructions loads A just once.
  assign enterRise = enter & ~enter_q;

  // State register plus the one-cycle delayed Enter level. enter_q comes
  // out of reset high so a key held through clear cannot look like a press.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_START;
      enter_q <= 1'b1;
    end else begin
      state_q <= state_d;
      enter_q <= enter;
    end
  end

  // Next-state logic. The opcode is looked at only in DECODE, where IR has
  // already been loaded by the preceding FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START:  state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = exec_state(IR75);
      ST_LOAD,
      ST_STORE,
      ST_ADD,
      ST_SUB,
      ST_JZ,
      ST_JPOS:   state_d = ST_START;
      ST_INPUT:  state_d = enterRise ? ST_START : ST_INPUT;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_START;
    endcase
  end

  // Output decode. Mostly Moore from the registered state; the exceptions
  // are PCload in the conditional jumps (follows the live flag) and Aload
  // in INPUT (follows the Enter edge), so those react in the same cycle.
  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = ASEL_ALU;
    Aload   = 1'b0;
    Sub     = 1'b0;
    halted  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      ST_DECODE: begin
        Meminst = 1'b1;
      end
      ST_LOAD: begin
        Meminst = 1'b1;
        Asel    = ASEL_RAM;
        Aload   = 1'b1;
      end
      ST_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      ST_ADD: begin
        Meminst = 1'b1;
        Asel    = ASEL_ALU;
        Aload   = 1'b1;
      end
      ST_SUB: begin
        Meminst = 1'b1;
        Asel    = ASEL_ALU;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      ST_INPUT: begin
        Asel  = ASEL_IN;
        Aload = enterRise;
      end
      ST_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      ST_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state = state_q;

endmodule
